conv_acc_bias: RTL and testbench

- Per-output-channel MAC stage directly upstream of the 8-bit bound/clamp stage.
- Accepts a window of K_NUM (activation, weight) beats and accumulates signed products.
- Adds a per-window bias and presents one AB_BW-bit signed result with a one-cycle valid pulse.
- The downstream clamp consumes the result unconditionally; this block applies no clamping or scaling.

---
 rtl/conv_acc_bias_pkg.sv | 37 +++
 rtl/conv_acc_bias_if.sv | 38 +++
 rtl/conv_acc_bias_acc_mul_reg.sv | 32 +++
 rtl/conv_acc_bias.sv | 134 +++++++++++++
 tb/tb_conv_acc_bias.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/conv_acc_bias_pkg.sv
// Shared definitions for the conv MAC stage and the downstream bound/clamp stage:
// default widths, FSM state encoding and the saturating add used under ACC_BIAS_SAT_EN.
package conv_acc_bias_pkg;

  localparam int D_BW_DEF  = 8;
  localparam int W_BW_DEF  = 8;
  localparam int AB_BW_DEF = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } cab_state_e;

  // Operands arrive sign-extended from w bits, so the 64-bit sum never overflows.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w,
                                                 output logic ovf);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    if (s > hi) begin
      s   = hi;
      ovf = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      ovf = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_acc_bias_if.sv
// Beat/result bus between the window feeder and conv_acc_bias.
// o_sat exists only when ACC_BIAS_SAT_EN is defined.
interface conv_acc_bias_if
  import conv_acc_bias_pkg::*;
#(
  parameter int D_BW  = D_BW_DEF,
  parameter int W_BW  = W_BW_DEF,
  parameter int AB_BW = AB_BW_DEF
);
  logic                    i_clear;
  logic                    i_valid;
  logic                    o_ready;
  logic signed [D_BW-1:0]  i_data;
  logic signed [W_BW-1:0]  i_weight;
  logic signed [AB_BW-1:0] i_bias;
  logic signed [AB_BW-1:0] o_acc_bias;
  logic                    o_valid;
`ifdef ACC_BIAS_SAT_EN
  logic                    o_sat;
`endif

  modport master (
    output i_clear, i_valid, i_data, i_weight, i_bias,
    input  o_ready, o_acc_bias, o_valid
`ifdef ACC_BIAS_SAT_EN
    , input o_sat
`endif
  );

  modport slave (
    input  i_clear, i_valid, i_data, i_weight, i_bias,
    output o_ready, o_acc_bias, o_valid
`ifdef ACC_BIAS_SAT_EN
    , output o_sat
`endif
  );

endinterface

// File: rtl/conv_acc_bias_acc_mul_reg.sv
// Registered signed multiply; the full D_BW+W_BW product is sign-extended to AB_BW.
module acc_mul_reg #(
  parameter int D_BW  = 8,
  parameter int W_BW  = 8,
  parameter int AB_BW = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [D_BW-1:0]  a,
  input  logic signed [W_BW-1:0]  b,
  output logic signed [AB_BW-1:0] prod_p1
);
  localparam int P_BW = D_BW + W_BW;

  logic signed [P_BW-1:0] prod_p0;

  assign prod_p0 = P_BW'(a) * P_BW'(b);

  // p0 -> p1: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1 <= '0;
    end else if (clr) begin
      prod_p1 <= '0;
    end else if (en) begin
      prod_p1 <= AB_BW'(prod_p0);
    end
  end

endmodule

// File: rtl/conv_acc_bias.sv
// Per-output-channel window MAC with per-window bias, feeding the 8-bit bound stage.
// Define ACC_BIAS_SAT_EN for saturating adds and the sticky o_sat flag; default build wraps.
module conv_acc_bias
  import conv_acc_bias_pkg::*;
#(
  parameter int D_BW   = D_BW_DEF,
  parameter int W_BW   = W_BW_DEF,
  parameter int AB_BW  = AB_BW_DEF,
  parameter int K_NUM  = 9,
  parameter int CNT_BW = $clog2(K_NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_acc_bias_if.slave  bus
);
  cab_state_e              state_q, state_d;
  logic [CNT_BW-1:0]       cnt_q;
  logic                    drain_q;
  logic                    accept;
  logic signed [AB_BW-1:0] prod_p1;
  logic signed [AB_BW-1:0] acc_p2;
  logic signed [AB_BW-1:0] bias_q;
  logic signed [AB_BW-1:0] acc_bias_q;
  logic                    vld_q;
  logic signed [AB_BW-1:0] acc_sum;
  logic signed [AB_BW-1:0] out_sum;

  assign bus.o_ready    = (state_q != DRAIN);
  assign accept         = bus.i_valid & bus.o_ready & ~bus.i_clear;
  assign bus.o_acc_bias = acc_bias_q;
  assign bus.o_valid    = vld_q;

  acc_mul_reg #(.D_BW(D_BW), .W_BW(W_BW), .AB_BW(AB_BW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (accept),
    .clr     (bus.i_clear),
    .a       (bus.i_data),
    .b       (bus.i_weight),
    .prod_p1 (prod_p1)
  );

`ifdef ACC_BIAS_SAT_EN
  logic acc_ovf, out_ovf, sat_q, sat_out_q;

  always_comb begin
    acc_ovf = 1'b0;
    out_ovf = 1'b0;
    acc_sum = AB_BW'(sat_add(64'(acc_p2), 64'(prod_p1), AB_BW, acc_ovf));
    out_sum = AB_BW'(sat_add(64'(acc_p2), 64'(bias_q), AB_BW, out_ovf));
  end

  // Sticky per window: cleared on the first beat, published with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q     <= 1'b0;
      sat_out_q <= 1'b0;
    end else if (bus.i_clear) begin
      sat_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (accept) sat_q <= 1'b0;
        ACC:     if (accept && acc_ovf) sat_q <= 1'b1;
        DRAIN:   if (!drain_q) sat_q <= sat_q | acc_ovf;
                 else sat_out_q <= sat_q | out_ovf;
        default: sat_q <= 1'b0;
      endcase
    end
  end

  assign bus.o_sat = sat_out_q;
`else
  assign acc_sum = acc_p2 + prod_p1;
  assign out_sum = acc_p2 + bias_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACC;
      ACC:     if (accept && cnt_q == CNT_BW'(K_NUM - 1)) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // p1 -> p2: accumulate previous product; DRAIN folds in the last product, then the bias
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      acc_p2     <= '0;
      bias_q     <= '0;
      acc_bias_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.i_clear) begin
        cnt_q   <= '0;
        drain_q <= 1'b0;
        acc_p2  <= '0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            cnt_q  <= CNT_BW'(1);
            acc_p2 <= '0;
            bias_q <= bus.i_bias;
          end
          ACC: if (accept) begin
            cnt_q  <= cnt_q + CNT_BW'(1);
            acc_p2 <= acc_sum;
          end
          DRAIN: if (!drain_q) begin
            acc_p2  <= acc_sum;
            drain_q <= 1'b1;
          end else begin
            drain_q    <= 1'b0;
            cnt_q      <= '0;
            acc_bias_q <= out_sum;
            vld_q      <= 1'b1;
          end
          default: cnt_q <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_acc_bias.sv
// Directed bench for conv_acc_bias (K_NUM=9); checks latency, stalls, clear, wrap/saturation and reset.
module tb_conv_acc_bias;
  localparam int D_BW  = 8;
  localparam int W_BW  = 8;
  localparam int AB_BW = 21;
  localparam int K_NUM = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  conv_acc_bias_if #(.D_BW(D_BW), .W_BW(W_BW), .AB_BW(AB_BW)) bus ();

  conv_acc_bias #(.D_BW(D_BW), .W_BW(W_BW), .AB_BW(AB_BW), .K_NUM(K_NUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feeds K_NUM beats; later beats carry junk bias that must be ignored.
  task automatic feed(input int d, input int w, input int bias, input bit gaps);
    for (int k = 0; k < K_NUM; k++) begin
      bus.i_valid  = 1'b1;
      bus.i_data   = D_BW'(d);
      bus.i_weight = W_BW'(w);
      bus.i_bias   = (k == 0) ? AB_BW'(bias) : AB_BW'(12345 + 1000 * k);
      tick();
      bus.i_valid = 1'b0;
      if (gaps && k != K_NUM - 1) begin
        bus.i_data   = D_BW'(99);
        bus.i_weight = W_BW'(99);
        tick();
      end
    end
  endtask

  task automatic run_window(input string tag, input int d, input int w, input int bias,
                            input bit gaps, input int exp);
    feed(d, w, bias, gaps);
    chk({tag, "_rdy_n1"}, 32'(bus.o_ready), 0);
    chk({tag, "_vld_n1"}, 32'(bus.o_valid), 0);
    tick();
    chk({tag, "_rdy_n2"}, 32'(bus.o_ready), 0);
    chk({tag, "_vld_n2"}, 32'(bus.o_valid), 0);
    tick();
    chk({tag, "_vld"}, 32'(bus.o_valid), 1);
    chk({tag, "_acc"}, 32'(bus.o_acc_bias), exp);
    chk({tag, "_rdy"}, 32'(bus.o_ready), 1);
    tick();
    chk({tag, "_vld_off"}, 32'(bus.o_valid), 0);
    chk({tag, "_hold"}, 32'(bus.o_acc_bias), exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.i_clear  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus.i_weight = '0;
    bus.i_bias   = '0;
    tick();
    tick();
    chk("rst_rdy", 32'(bus.o_ready), 1);
    chk("rst_vld", 32'(bus.o_valid), 0);
    chk("rst_acc", 32'(bus.o_acc_bias), 0);
    rst_n = 1'b1;
    tick();

    run_window("ones", 1, 2, 5, 1'b0, 23);
    run_window("neg", -128, -128, -100, 1'b0, 147356);
    run_window("gaps", 3, -1, 0, 1'b1, -27);

    // Clear together with beat 5 drops the partial window.
    for (int k = 0; k < 4; k++) begin
      bus.i_valid  = 1'b1;
      bus.i_data   = D_BW'(5);
      bus.i_weight = W_BW'(5);
      bus.i_bias   = AB_BW'(50);
      tick();
    end
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("clr5_vld", 32'(bus.o_valid), 0);
    chk("clr5_rdy", 32'(bus.o_ready), 1);
    chk("clr5_hold", 32'(bus.o_acc_bias), -27);

    // Clear in the second DRAIN cycle suppresses the pulse.
    feed(4, 4, 0, 1'b0);
    tick();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("clrd_vld", 32'(bus.o_valid), 0);
    chk("clrd_hold", 32'(bus.o_acc_bias), -27);
    tick();
    chk("clrd_vld2", 32'(bus.o_valid), 0);
    chk("clrd_rdy", 32'(bus.o_ready), 1);

    run_window("clean", 1, 1, 0, 1'b0, 9);

`ifdef ACC_BIAS_SAT_EN
    run_window("sat", 127, 127, 1048575, 1'b0, 1048575);
    chk("sat_flag", 32'(bus.o_sat), 1);
    run_window("nosat", 1, 1, 0, 1'b0, 9);
    chk("nosat_flag", 32'(bus.o_sat), 0);
`else
    run_window("wrap", 127, 127, 1048575, 1'b0, -903416);
`endif

    // Reset mid-ACC clears outputs immediately.
    for (int k = 0; k < 4; k++) begin
      bus.i_valid  = 1'b1;
      bus.i_data   = D_BW'(7);
      bus.i_weight = W_BW'(7);
      bus.i_bias   = AB_BW'(3);
      tick();
    end
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_acc", 32'(bus.o_acc_bias), 0);
    chk("mrst_vld", 32'(bus.o_valid), 0);
    chk("mrst_rdy", 32'(bus.o_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_quiet", 32'(bus.o_valid), 0);

    run_window("post_rst", 2, 2, 1, 1'b0, 37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
